// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: multi-stage valid/ready register pipeline with bubble
// collapsing, flush, synchronous clear and a registered occupancy count.
// NEGEDGE chooses whether the state registers capture on the falling edge (1)
// or on the rising edge (0) of clk.
module pipe_reg_elastic #(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 2,
    parameter int NEGEDGE = 1
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [$clog2(STAGES+1)-1:0] count
);

    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    // Readiness ripples back from the output: a stage can load when it is empty or its occupant moves on.
    always_comb begin
        rdy = '0;
        rdy[STAGES-1] = out_ready | ~v_q[STAGES-1];
        for (int unsigned k = 1; k < STAGES; k++) begin
            rdy[STAGES-1-k] = rdy[STAGES-k] | ~v_q[STAGES-1-k];
        end
    end

    // Next stage contents: flush empties every stage but keeps the data registers; ready stages take their upstream item.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            v_d = '0;
        end else begin
            if (rdy[0]) begin
                v_d[0] = in_valid;
                if (in_valid) begin
                    data_d[0] = in_data;
                end
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    // Occupancy of the next state, so count moves on the same edge as the valid bits.
    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    // Only one capture process exists, on the edge picked by NEGEDGE; clr overrides everything.
    if (NEGEDGE != 0) begin : g_fall
        always_ff @(negedge clk) begin
            if (clr) begin
                v_q     <= '0;
                data_q  <= '{default: '0};
                count_q <= '0;
            end else begin
                v_q     <= v_d;
                data_q  <= data_d;
                count_q <= count_d;
            end
        end
    end else begin : g_rise
        always_ff @(posedge clk) begin
            if (clr) begin
                v_q     <= '0;
                data_q  <= '{default: '0};
                count_q <= '0;
            end else begin
                v_q     <= v_d;
                data_q  <= data_d;
                count_q <= count_d;
            end
        end
    end

    assign in_ready  = rdy[0] & ~flush & ~clr;
    assign out_valid = v_q[STAGES-1] & ~flush & ~clr;
    assign out_data  = data_q[STAGES-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: three configurations (3 stages falling edge,
// 3 stages rising edge, 1 stage falling edge), each driven by directed
// scenarios and random traffic. The reference model keeps the held items as a
// queue with positions that compact toward the output; a separate monitor
// matches emitted data against a scoreboard queue.
module tb_pipe_reg_elastic;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } item_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_cfg
        localparam int S   = (g == 2) ? 1 : 3;
        localparam int NEG = (g == 1) ? 0 : 1;
        localparam int CW  = $clog2(S + 1);

        logic          flush, clr, in_valid, in_ready, out_valid, out_ready;
        logic [W-1:0]  in_data, out_data;
        logic [CW-1:0] count;
        bit            armed  = 1'b0;
        bit            done_g = 1'b0;
        item_t         mq[$];
        logic [W-1:0]  expq[$];

        pipe_reg_elastic #(.WIDTH(W), .STAGES(S), .NEGEDGE(NEG)) u_dut (
            .clk      (clk),
            .clr      (clr),
            .flush    (flush),
            .in_valid (in_valid),
            .in_data  (in_data),
            .in_ready (in_ready),
            .out_valid(out_valid),
            .out_data (out_data),
            .out_ready(out_ready),
            .count    (count)
        );

        function automatic string nm(input string s);
            return $sformatf("cfg%0d(S=%0d,NEG=%0d) %s", g, S, NEG, s);
        endfunction

        task automatic wait_active();
            if (NEG != 0) @(negedge clk);
            else @(posedge clk);
        endtask

        task automatic wait_inactive();
            if (NEG != 0) @(posedge clk);
            else @(negedge clk);
        endtask

        // One clock: drive at edge+1, check against the model at edge+2, advance the model at the next active edge.
        task automatic cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                             input bit fl, input bit cl);
            bit    acc, emit, m_ov, m_ir;
            item_t it;
            in_valid  = iv;
            in_data   = id;
            out_ready = ordy;
            flush     = fl;
            clr       = cl;
            #1;
            m_ov = !fl && !cl && mq.size() > 0 && mq[0].pos == S - 1;
            m_ir = !fl && !cl && (mq.size() < S || ordy);
            check(nm("out_valid"), out_valid, m_ov);
            check(nm("in_ready"), in_ready, m_ir);
            check(nm("count"), count, mq.size());
            acc  = iv && m_ir;
            emit = m_ov && ordy;
            if (acc) expq.push_back(id);
            wait_active();
            if (cl || fl) begin
                mq.delete();
                expq.delete();
            end else begin
                if (emit) void'(mq.pop_front());
                if (acc) begin
                    it.d   = id;
                    it.pos = -1;
                    mq.push_back(it);
                end
                for (int j = 0; j < mq.size(); j++) begin
                    mq[j].pos = (mq[j].pos + 1 < S - 1 - j) ? mq[j].pos + 1 : S - 1 - j;
                end
            end
            #1;
        endtask

        task automatic stream(input logic [W-1:0] base, input int n, output int first);
            first = -1;
            for (int k = 1; k <= n; k++) begin
                cycle(1'b1, base + W'(k - 1), 1'b1, 1'b0, 1'b0);
                if (first < 0 && out_valid) first = k;
            end
        endtask

        task automatic idle(input int n, input bit ordy);
            for (int k = 0; k < n; k++) cycle(1'b0, '0, ordy, 1'b0, 1'b0);
        endtask

        initial begin : driver
            int fv;
            in_valid  = 1'b0;
            in_data   = '0;
            out_ready = 1'b0;
            flush     = 1'b0;
            clr       = 1'b1;
            wait_active();
            #1;
            armed = 1'b1;
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            check(nm("reset count"), count, 0);
            check(nm("reset out_data"), out_data, 0);
            check(nm("reset out_valid"), out_valid, 0);
            check(nm("reset in_ready"), in_ready, 0);

            // streaming
            stream(8'h01, S + 6, fv);
            check(nm("stream latency"), fv, S);
            check(nm("stream count steady"), count, S);
            idle(S + 1, 1'b1);

            // backpressure
            for (int k = 0; k < S; k++) cycle(1'b1, 8'hA1 + W'(k), 1'b0, 1'b0, 1'b0);
            check(nm("bp count full"), count, S);
            check(nm("bp in_ready"), in_ready, 0);
            check(nm("bp out_data head"), out_data, 8'hA1);
            idle(S, 1'b1);
            check(nm("bp count drained"), count, 0);

            // bubble collapse
            cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
            check(nm("bubble count"), count, (S < 2) ? S : 2);
            check(nm("bubble in_ready"), in_ready, (S > 2) ? 1 : 0);
            check(nm("bubble out_valid"), out_valid, 1);
            check(nm("bubble out_data"), out_data, 8'h10);
            idle(S + 1, 1'b1);

            // flush of a full pipe with an item offered
            for (int k = 0; k < S; k++) cycle(1'b1, 8'h30 + W'(k), 1'b0, 1'b0, 1'b0);
            check(nm("pre-flush count"), count, S);
            cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
            check(nm("flush count"), count, 0);
            idle(S + 1, 1'b1);
            check(nm("post-flush out_valid"), out_valid, 0);

            // clr together with flush mid-stream
            stream(8'h60, 5, fv);
            cycle(1'b1, 8'h70, 1'b1, 1'b1, 1'b1);
            check(nm("midreset count"), count, 0);
            check(nm("midreset out_data"), out_data, 0);
            check(nm("midreset out_valid"), out_valid, 0);
            stream(8'h80, S + 4, fv);
            check(nm("restart latency"), fv, S);
            idle(S + 1, 1'b1);

            // random traffic
            for (int k = 0; k < 600; k++) begin
                int r;
                r = int'($urandom_range(0, 63));
                cycle(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0,
                      r == 1 || r == 2, r == 0);
            end
            idle(S + 2, 1'b1);
            check(nm("final count"), count, 0);
            check(nm("final scoreboard empty"), expq.size(), 0);
            done_g = 1'b1;
        end

        // Monitor: every presented output must be the oldest outstanding item; it retires when taken.
        initial begin : monitor
            wait (armed);
            while (!done_g) begin
                wait_active();
                #3;
                if (out_valid) begin
                    if (expq.size() == 0) begin
                        check(nm("out_valid with nothing outstanding"), out_valid, 0);
                    end else begin
                        check(nm("out_data order"), out_data, expq[0]);
                        if (out_ready) void'(expq.pop_front());
                    end
                end
            end
        end

        // Registered outputs must not move on the inactive clock edge.
        initial begin : edge_watch
            logic [CW-1:0] c0;
            logic [W-1:0]  d0;
            wait (armed);
            while (!done_g) begin
                wait_inactive();
                c0 = count;
                d0 = out_data;
                #1;
                check(nm("count stable on inactive edge"), count, c0);
                check(nm("out_data stable on inactive edge"), out_data, d0);
            end
        end
    end

    initial begin : finisher
        int c;
        c = 0;
        while (!(gen_cfg[0].done_g && gen_cfg[1].done_g && gen_cfg[2].done_g) && c < 20000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 20000) begin
            n_total++;
            $display("FAIL timeout: done flags %0b%0b%0b, required 111",
                     gen_cfg[2].done_g, gen_cfg[1].done_g, gen_cfg[0].done_g);
        end
        #20;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning payload width in bits (legal values: 1 or more).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning number of register stages (legal values: 1 or more).
REQ-003 The block SHALL have parameter NEGEDGE, default 1, meaning capture on the falling clock edge when 1 and on the rising edge when 0.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update only on the active edge selected by NEGEDGE.
REQ-005 The block SHALL have port clr, input, 1 bit, a synchronous, active-high reset, sampled on the active edge.
REQ-006 The block SHALL have port flush, input, 1 bit, which discards all held items.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning upstream presents an item.
REQ-008 The block SHALL have port in_data, input, WIDTH bits, the upstream payload.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the item at the next active edge.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the last stage holds an item.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, the last-stage payload.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning downstream takes the item at the next active edge.
REQ-013 The block SHALL have port count, output, $clog2(STAGES+1) bits, the number of valid stages.

Function
REQ-014 Each stage i SHALL hold a data register and a valid bit v[i]; stage 0 is the input side, stage STAGES-1 drives the output side.
REQ-015 Readiness SHALL be rdy[STAGES-1] = out_ready | ~v[STAGES-1], and rdy[i] = rdy[i+1] | ~v[i] for all other stages (bubble collapsing).
REQ-016 in_ready SHALL equal rdy[0] & ~flush & ~clr.
REQ-017 out_valid SHALL equal v[STAGES-1] & ~flush & ~clr, and out_data SHALL equal the stage STAGES-1 data register at all times.
REQ-018 A transfer SHALL occur on an active edge where the corresponding valid and ready are both high; nothing else SHALL be a transfer.
REQ-019 On an active edge with rdy[i] high, v[i] SHALL load the upstream valid (in_valid for stage 0, v[i-1] otherwise).
REQ-020 On that same edge, the stage i data register SHALL load the upstream data only when the upstream valid is 1; otherwise it SHALL hold its value.
REQ-021 Stages with rdy[i] low SHALL hold both data and valid.
REQ-022 Latency: an item accepted into an empty pipe with out_ready low SHALL raise out_valid after the STAGES-th active edge, counting the acceptance edge as the first.
REQ-023 With out_ready held high and in_valid held high, throughput SHALL be one item per cycle with no bubbles.
REQ-024 Full pipe (count = STAGES) with out_ready high SHALL accept and emit on the same edge, and count SHALL be unchanged.
REQ-025 Full pipe with out_ready low SHALL hold in_ready at 0 and leave the contents unchanged.
REQ-026 A bubble between valid stages SHALL be absorbed while the output is stalled; upstream items advance into empty stages.
REQ-027 flush high at an active edge SHALL clear all v[i] to 0; data registers SHALL hold; no transfer occurs that cycle.
REQ-028 count SHALL be the registered population of the v bits, updated on the same edge as the v bits.
REQ-029 Items SHALL leave in acceptance order; no item SHALL be duplicated or dropped except by flush or clr.

Reset
REQ-030 clr high at an active edge SHALL set all v[i] = 0, all data registers = 0, and count = 0.
REQ-031 clr SHALL take priority over flush and over any transfer.
REQ-032 While clr is high, in_ready = 0, out_valid = 0, and out_data = 0 from the first active edge onward.
REQ-033 The state after clr asserted mid-stream SHALL be identical to the post-reset state; in-flight items are lost.
REQ-034 Power-up state before the first clr SHALL be undefined, and the bench SHALL apply clr first.

Verification
REQ-035 Bench with STAGES=3, WIDTH=8: streaming -- clr, then in_valid=1 with data 0x01,0x02,0x03,... and out_ready=1 -> out_valid rises after 3rd edge, out_data 0x01,0x02,... one per cycle, count steady at 3.
REQ-036 Bench with STAGES=3, WIDTH=8: backpressure -- out_ready=0, push 0xA1,0xA2,0xA3 -> count=3, in_ready=0, out_data=0xA1; raise out_ready for 3 cycles -> 0xA1,0xA2,0xA3 in order, count returns to 0.
REQ-037 Bench with STAGES=3, WIDTH=8: bubble collapse -- out_ready=0, push 0x10, idle 1 cycle, push 0x20 -> both held in stages 2 and 1, count=2, in_ready=1.
REQ-038 Bench with STAGES=3, WIDTH=8: flush -- full pipe, flush=1 with in_valid=1 for one edge -> in_ready=0, out_valid=0 during flush, count=0 after, input item not accepted.
REQ-039 Bench with STAGES=3, WIDTH=8: reset mid-stream -- clr and flush both high while streaming -> next edge count=0, out_data=0x00, out_valid=0; stream restarts with latency 3.
REQ-040 Bench mode sweep -- repeat REQ-035 with NEGEDGE=0 and with STAGES=1 -> identical ordering; for NEGEDGE=1 state changes occur only on falling edges.
